store_writer: RTL

STORE_WRITER -- requirements
Module: store_writer

---
 rtl/store_writer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/store_writer.sv
// store_writer
//   Turns one scalar store request (1/2/4/8 bytes, right-justified data) into
//   a single-beat AXI4 write on a 64-bit bus. It shifts the data onto its byte
//   lanes and builds the byte strobe from the access width and the low address
//   bits. It then waits for the B response and reports completion with a
//   one-cycle pulse. Misaligned requests are rejected with an error and
//   produce no bus traffic. Only one write is ever outstanding.
//
// Ports
//   clock, reset              single rising-edge clock, synchronous active-high reset
//   req_valid/req_ready       store request handshake (ready only while idle)
//   req_addr, req_data        byte address, right-justified store data
//   req_width                 0=1B, 1=2B, 2=4B, 3=8B
//   resp_valid, resp_err      one-cycle completion pulse and error flag
//   aw*                       AXI4 write-address channel (master)
//   w*                        AXI4 write-data channel (master)
//   b*                        AXI4 write-response channel (master side)
module store_writer #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int AXI_ID = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_width,
  output logic              resp_valid,
  output logic              resp_err,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awid,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp
);

  localparam logic [3:0] ID = 4'(AXI_ID);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // A width code is aligned when the address bits below its size are zero.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [2:0] lo);
    logic mis;
    case (width)
      2'd0:    mis = 1'b0;
      2'd1:    mis = lo[0];
      2'd2:    mis = |lo[1:0];
      default: mis = |lo;
    endcase
    return mis;
  endfunction

  // Base strobe for the width, moved onto the addressed lanes. Bits shifted
  // past lane 7 are dropped; that only happens for misaligned requests, which
  // never reach the bus.
  function automatic logic [7:0] lane_strobe(input logic [1:0] width, input logic [2:0] lo);
    logic [7:0] base;
    case (width)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lo;
  endfunction

  function automatic logic [DATA_W-1:0] lane_data(input logic [DATA_W-1:0] data,
                                                  input logic [2:0]        lo);
    return data << {lo, 3'b000};
  endfunction

  logic              aw_pend_q;
  logic              w_pend_q;
  logic              err_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wstrb_q;
  logic [2:0]        awsize_q;

  logic              accept;
  logic              req_mis;
  logic              aw_done;
  logic              w_done;

  assign req_mis = is_misaligned(req_width, req_addr[2:0]);
  assign accept  = (state_q == IDLE) && req_valid;
  // A channel counts as done if it finished earlier or completes this cycle,
  // so same-cycle AW and W handshakes move on together.
  assign aw_done = !aw_pend_q || awready;
  assign w_done  = !w_pend_q || wready;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    bready     = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_mis ? RESP : SEND;
      end
      SEND: begin
        if (aw_done && w_done) state_d = WAIT_B;
      end
      WAIT_B: begin
        bready = 1'b1;
        if (bvalid) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture stage: request is latched and lane-aligned on acceptance; each
  // AXI valid then holds until its own handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      err_q     <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awsize_q  <= '0;
    end else if (accept) begin
      aw_pend_q <= !req_mis;
      w_pend_q  <= !req_mis;
      err_q     <= req_mis;
      awaddr_q  <= req_addr;
      wdata_q   <= lane_data(req_data, req_addr[2:0]);
      wstrb_q   <= lane_strobe(req_width, req_addr[2:0]);
      awsize_q  <= {1'b0, req_width};
    end else begin
      if (aw_pend_q && awready) aw_pend_q <= 1'b0;
      if (w_pend_q && wready)   w_pend_q  <= 1'b0;
      if ((state_q == WAIT_B) && bvalid)
        err_q <= (bresp != 2'b00) || (bid != ID);
    end
  end

  assign awvalid = aw_pend_q;
  assign awaddr  = awaddr_q;
  assign awid    = ID;
  assign awlen   = 8'd0;
  assign awsize  = awsize_q;
  assign awburst = 2'b01;
  assign wvalid  = w_pend_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

endmodule
